ysyx_25030093_lsu_sram: RTL

Data-memory responder on the far side of the LSU's valid/ready load/store interface. It accepts one word-aligned load or store request at a time and services it against an internal byte-maskable SRAM after a fixed latency. It then returns read data or an error on a response channel with its own valid/ready handshake. It replaces the combinational DPI memory stub so the LSU state machine sees real multi-cycle latency and backpressure.

---
 rtl/ysyx_25030093_mem_pkg.sv | 15 +
 rtl/ysyx_25030093_sram_array.sv | 36 +++
 rtl/ysyx_25030093_lsu_sram.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_mem_pkg.sv
// Shared definitions for the LSU data-memory responder and the LSU handshake side.
// Holds the state encoding, the default memory base address and the latency ceiling.
package ysyx_25030093_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int          MAX_LATENCY       = 15;
  localparam int          CNT_W             = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/ysyx_25030093_sram_array.sv
// Word-organised SRAM with per-byte write strobes.
// Both read and write are synchronous; read data holds until the next enabled read.
module ysyx_25030093_sram_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_wstrb,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the array and its read register take no reset; clearing a RAM
  // would need a sequencer, and stored contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wstrb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_25030093_lsu_sram.sv
// Fixed-latency load/store responder: valid/ready request in, valid/ready response out.
// The access commits on the edge that enters RESP; faults suppress the array access.
module ysyx_25030093_lsu_sram
  import ysyx_25030093_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0]     END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  mem_state_e       r_state;
  mem_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_err;
  logic             r_load_ok;

  logic             w_accept;
  logic             w_commit;
  logic             w_use_live;
  logic [31:0]      w_c_addr;
  logic             w_c_wen;
  logic [31:0]      w_c_wdata;
  logic [3:0]       w_c_wstrb;
  logic             w_fault;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_arr_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block can leave a value implied, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_commit    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);

  // With LATENCY==1 the commit happens on the accept edge, so the live request is used.
  assign w_use_live = (r_state == IDLE);
  assign w_c_addr   = w_use_live ? req_addr  : r_addr;
  assign w_c_wen    = w_use_live ? req_wen   : r_wen;
  assign w_c_wdata  = w_use_live ? req_wdata : r_wdata;
  assign w_c_wstrb  = w_use_live ? req_wstrb : r_wstrb;

  assign w_fault = (w_c_addr[1:0] != 2'b00) ||
                   (w_c_addr < BASE_ADDR) ||
                   ({1'b0, w_c_addr} >= END_ADDR);
  assign w_idx   = AW'((w_c_addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_addr  <= req_addr;
        r_wen   <= req_wen;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_err     <= w_fault;
        r_load_ok <= !w_c_wen && !w_fault;
      end
    end
  end

  ysyx_25030093_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_en    (w_commit && !w_fault),
    .i_we    (w_c_wen),
    .i_wstrb (w_c_wstrb),
    .i_addr  (w_idx),
    .i_wdata (w_c_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The array read register is only refreshed by a committing load, so it is stable in RESP.
  assign resp_rdata = r_load_ok ? w_arr_rdata : 32'h0;
  assign resp_err   = r_err;

endmodule
